// File: rtl/alu_result_stage.sv
// Result buffer behind the ALU: DEPTH-entry FIFO of {opcode, result} with valid/ready on both sides.
// Optional head flags (out_zero/out_neg) are built only when ALU_RESULT_FLAGS_EN is defined.
module alu_result_stage #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_result,
   input  logic [3:0]                 in_opcode,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [3:0]                 out_opcode,
   output logic                       out_zero,
   output logic                       out_neg,
   output logic [$clog2(DEPTH):0]     count,
   output logic [1:0]                 occ_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } occ_state_t;

   logic [WIDTH+3:0] mem [DEPTH];
   logic [PW-1:0]    wptr, rptr, wptr_d, rptr_d, count_d;
   logic [WIDTH+3:0] head;
   logic             full, empty, push, pop;
   occ_state_t       state_q, state_d;

   assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign empty     = (wptr == rptr);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = wptr - rptr;
   assign occ_state = state_q;

   always_comb begin
      wptr_d  = wptr;
      rptr_d  = rptr;
      state_d = state_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push) wptr_d = wptr + PW'(1);
         if (pop)  rptr_d = rptr + PW'(1);
      end
      count_d = wptr_d - rptr_d;
      if (count_d == '0)
         state_d = ST_EMPTY;
      else if (count_d == PW'(DEPTH))
         state_d = ST_FULL;
      else
         state_d = ST_PARTIAL;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wptr    <= '0;
         rptr    <= '0;
         state_q <= ST_EMPTY;
      end else begin
         wptr    <= wptr_d;
         rptr    <= rptr_d;
         state_q <= state_d;
      end
   end

   // Storage is deliberately left unreset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr[AW-1:0]] <= {in_opcode, in_result};
   end

   assign head       = mem[rptr[AW-1:0]];
   assign out_data   = head[WIDTH-1:0];
   assign out_opcode = head[WIDTH+3:WIDTH];

`ifdef ALU_RESULT_FLAGS_EN
   assign out_zero = (out_data == '0) && out_valid;
   assign out_neg  = out_data[WIDTH-1] && out_valid;
`else
   assign out_zero = 1'b0;
   assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: driver pushes expected entries into a queue, a negedge monitor pops and compares.
module tb_alu_result_stage;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

`ifdef ALU_RESULT_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             clr_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_result;
   logic [3:0]       in_opcode;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [3:0]       out_opcode;
   logic             out_zero;
   logic             out_neg;
   logic [1:0]       count;
   logic [1:0]       occ_state;

   int total = 0;
   int bad   = 0;
   logic [WIDTH+3:0] exp_q[$];

   alu_result_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .clr_n(clr_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_opcode(in_opcode),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_opcode(out_opcode),
      .out_zero(out_zero), .out_neg(out_neg), .count(count), .occ_state(occ_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver: present one word for one edge; record it when the bench expects acceptance
   task automatic push_word(input logic [WIDTH-1:0] d, input logic [3:0] op, input bit accept);
      in_valid  = 1'b1;
      in_result = d;
      in_opcode = op;
      if (accept) exp_q.push_back({op, d});
      step();
      in_valid  = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (clr_n && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got 0x%0h op %0d expected nothing at %0t", out_data, out_opcode, $time);
         end else begin
            logic [WIDTH+3:0] e;
            e = exp_q.pop_front();
            check("out_data",   64'(out_data),   64'(e[WIDTH-1:0]));
            check("out_opcode", 64'(out_opcode), 64'(e[WIDTH+3:WIDTH]));
            check("out_zero",   64'(out_zero),   64'(FLAGS && (e[WIDTH-1:0] == '0)));
            check("out_neg",    64'(out_neg),    64'(FLAGS && e[WIDTH-1]));
         end
      end
   end

   initial begin
      clr_n = 1'b0; in_valid = 1'b0; in_result = '0; in_opcode = '0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 clr_n = 1'b1;

      // reset then idle
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_count",     64'(count),     64'd0);
      check("rst_zero",      64'(out_zero),  64'd0);
      check("rst_neg",       64'(out_neg),   64'd0);
      check("rst_state",     64'(occ_state), 64'd0);

      // fill with consumer stalled
      push_word(32'h0000_00F0, 4'd0, 1'b1);
      check("fill1_count", 64'(count),     64'd1);
      check("fill1_state", 64'(occ_state), 64'd1);
      push_word(32'hFFFF_FFFF, 4'd1, 1'b1);
      check("fill2_count",    64'(count),     64'd2);
      check("fill2_in_ready", 64'(in_ready),  64'd0);
      check("fill2_state",    64'(occ_state), 64'd2);
      push_word(32'h0000_1234, 4'd3, 1'b0);
      check("drop_count", 64'(count), 64'd2);
      check("full_head_data", 64'(out_data), 64'h0000_00F0);
      // drain
      out_ready = 1'b1;
      step();
      step();
      check("drain_out_valid", 64'(out_valid), 64'd0);
      check("drain_count",     64'(count),     64'd0);
      check("drain_state",     64'(occ_state), 64'd0);

      // simultaneous push/pop at count 1
      out_ready = 1'b0;
      push_word(32'h0000_0055, 4'd5, 1'b1);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push_word(WIDTH'(i), 4'(i), 1'b1);
         check("stream_count", 64'(count), 64'd1);
      end
      step();
      check("stream_end_count", 64'(count), 64'd0);
      out_ready = 1'b0;

      // zero flag
      push_word(32'h0000_0000, 4'd2, 1'b1);
      check("zero_valid", 64'(out_valid), 64'd1);
      check("zero_flag",  64'(out_zero),  64'(FLAGS));
      check("zero_neg",   64'(out_neg),   64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("zero_drained", 64'(count), 64'd0);

      // flush beats push and pop
      push_word(32'h0000_000A, 4'd3, 1'b1);
      push_word(32'h0000_000B, 4'd4, 1'b1);
      check("pre_flush_count", 64'(count), 64'd2);
      exp_q.delete();
      flush = 1'b1; in_valid = 1'b1; in_result = 32'h0000_000C; in_opcode = 4'd9; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_count", 64'(count),     64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_state", 64'(occ_state), 64'd0);
      repeat (3) step();
      check("post_flush_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // asynchronous reset mid-stream
      push_word(32'h0000_00DD, 4'd6, 1'b1);
      check("pre_rst_count", 64'(count), 64'd1);
      #2;
      clr_n = 1'b0;
      exp_q.delete();
      #1;
      check("async_out_valid", 64'(out_valid), 64'd0);
      check("async_count",     64'(count),     64'd0);
      step();
      clr_n = 1'b1;
      push_word(32'hA5A5_A5A5, 4'd7, 1'b1);
      check("post_rst_count", 64'(count),    64'd1);
      check("post_rst_data",  64'(out_data), 64'hA5A5_A5A5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("post_rst_empty", 64'(out_valid), 64'd0);

      step();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
